imm_ext_arbiter: RTL
====================

IMM_EXT_ARBITER -- requirements
Module: imm_ext_arbiter

Interface
REQ-001 SHALL have port: Clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: Reset  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port: ReqA  input  1  decode-stage request valid (requester A).
REQ-004 SHALL have port: ImmA  input  26  requester A instruction bits [25:0].
REQ-005 SHALL have port: CtrlA  input  3  requester A extension format.
REQ-006 SHALL have port: GntA  output  1  A request accepted this cycle.
REQ-007 SHALL have port: RspValidA  output  1  BusImmA updated this cycle.
REQ-008 SHALL have port: BusImmA  output  64  extended immediate for A.
REQ-009 SHALL have ports ReqB, ImmB, CtrlB, GntB, RspValidB, BusImmB: same widths and meanings for requester B (branch unit).

Function
REQ-010 SHALL implement one shared extension datapath; at most one request accepted per cycle.
REQ-011 SHALL decode Ctrl: 000 I = sign-extend Imm[21:10]; 001 D = sign-extend Imm[20:12]; 010 B = sign-extend Imm[25:0]; 011 CB = sign-extend Imm[23:5]; 1xx IW = zero-extend Imm[20:5], shifted left by 16*Imm[22:21].
REQ-012 SHALL assert Gnt combinationally in the cycle the request is accepted; the requester holds Req/Imm/Ctrl stable until it sees Gnt.
REQ-013 SHALL register the result: RspValid pulses exactly one cycle after Gnt, with BusImm valid in that same cycle.
REQ-014 SHALL hold BusImmX at its last value until the next RspValidX.
REQ-015 SHALL grant a single active requester every cycle it requests (back-to-back throughput 1/cycle).
REQ-016 SHALL use a 1-bit round-robin pointer when both request: grant the pointed requester, then point at the other.
REQ-017 SHALL leave the pointer unchanged when at most one requester is active.
REQ-018 SHALL guarantee a losing requester is granted on the next cycle if it still requests.
REQ-019 SHALL never assert GntA and GntB in the same cycle, and never assert Gnt without the matching Req.
REQ-020 SHALL return a response for a request dropped after its Gnt, with no further effect.

Reset
REQ-021 SHALL, while Reset is high, drive GntA/GntB low, RspValidA/RspValidB low, BusImmA/BusImmB = 64'h0, and point the pointer at A.
REQ-022 SHALL discard any request granted in the cycle Reset is asserted; no RspValid in the cycle after reset is released.

Configuration
REQ-023 SHALL, with IMM_EXT_STALL_CNT_EN defined, add outputs StallCntA/StallCntB (16 bits each): cycles ReqX high and GntX low, saturating at 16'hFFFF, cleared by Reset.
REQ-024 SHALL, with IMM_EXT_STALL_CNT_EN undefined, have neither the counters nor their ports; all other behaviour is identical.

Structure
REQ-025 SHALL place the Ctrl encodings (I, D, B, CB, IW) and the IW shift-amount constant in the shared package imm_ext_pkg.
REQ-026 SHALL put the combinational extension in one sub-module imm_extend (Imm 26, Ctrl 3 -> 64), instantiated once after the grant mux.

Verification
REQ-027 SHALL test: ReqA=1, CtrlA=000, ImmA[21:10]=12'hFFF -> GntA same cycle; next cycle RspValidA=1, BusImmA=64'hFFFF_FFFF_FFFF_FFFF.
REQ-028 SHALL test: both requesting after reset (A: CB, Imm[23:5]=19'h00010; B: B-format, Imm=26'h0000004) -> cycle0 GntA, cycle1 GntB; BusImmA=64'h10, BusImmB=64'h4.
REQ-029 SHALL test: CtrlB=100, Imm[22:21]=2'b11, Imm[20:5]=16'hBEEF -> BusImmB=64'hBEEF_0000_0000_0000.
REQ-030 SHALL test: ReqA held high for 4 cycles, ReqB low -> GntA 4 consecutive cycles, RspValidA 4 consecutive cycles, shifted by one.
REQ-031 SHALL test: Reset asserted in the GntA cycle -> no RspValidA next cycle, BusImmA=0, next dual request granted to A.
REQ-032 SHALL test, with IMM_EXT_STALL_CNT_EN defined: both requesting for 10 cycles -> StallCntA=5, StallCntB=5.

Source files
------------

// File: rtl/imm_ext_pkg.sv
// Shared constants for the immediate-extension arbiter: Ctrl format encodings,
// the IW shift granularity and the round-robin pointer encoding.
package imm_ext_pkg;

  typedef enum logic [2:0] {
    CTRL_I  = 3'b000,
    CTRL_D  = 3'b001,
    CTRL_B  = 3'b010,
    CTRL_CB = 3'b011,
    CTRL_IW = 3'b100
  } imm_ctrl_e;

  localparam int unsigned IW_SHIFT_UNIT = 16;

  typedef enum logic {
    PTR_A = 1'b0,
    PTR_B = 1'b1
  } rr_ptr_e;

  // IW places its 16-bit field in one of four halfword lanes.
  function automatic logic [5:0] iw_shamt(input logic [1:0] lane);
    return 6'(IW_SHIFT_UNIT * int'(lane));
  endfunction

endpackage

// File: rtl/imm_ext_arbiter_extend.sv
// Combinational immediate extension: 26-bit instruction field plus 3-bit
// format select produce a 64-bit sign- or zero-extended immediate.
module imm_extend
  import imm_ext_pkg::*;
(
  input  logic [25:0] imm,
  input  logic [2:0]  ctrl,
  output logic [63:0] ext
);

  always_comb begin
    ext = '0;
    if (ctrl[2]) begin
      // Any Ctrl with the top bit set is the wide-immediate format.
      ext = {48'b0, imm[20:5]} << iw_shamt(imm[22:21]);
    end else begin
      case (ctrl)
        CTRL_I:  ext = {{52{imm[21]}}, imm[21:10]};
        CTRL_D:  ext = {{55{imm[20]}}, imm[20:12]};
        CTRL_B:  ext = {{38{imm[25]}}, imm[25:0]};
        CTRL_CB: ext = {{45{imm[23]}}, imm[23:5]};
        default: ext = '0;
      endcase
    end
  end

endmodule

// File: rtl/imm_ext_arbiter.sv
// Two-requester round-robin arbiter in front of one shared immediate extender;
// results are registered per requester. Optional stall counters: IMM_EXT_STALL_CNT_EN.
module imm_ext_arbiter
  import imm_ext_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic        ReqA,
  input  logic [25:0] ImmA,
  input  logic [2:0]  CtrlA,
  output logic        GntA,
  output logic        RspValidA,
  output logic [63:0] BusImmA,
  input  logic        ReqB,
  input  logic [25:0] ImmB,
  input  logic [2:0]  CtrlB,
  output logic        GntB,
  output logic        RspValidB,
  output logic [63:0] BusImmB
`ifdef IMM_EXT_STALL_CNT_EN
  ,
  output logic [15:0] StallCntA,
  output logic [15:0] StallCntB
`endif
);

  rr_ptr_e     ptr_q, ptr_d;
  logic        gnt_a, gnt_b;
  logic [25:0] sel_imm;
  logic [2:0]  sel_ctrl;
  logic [63:0] ext_imm;
  logic        rsp_valid_a_q, rsp_valid_a_d, rsp_valid_b_q, rsp_valid_b_d;
  logic [63:0] bus_imm_a_q, bus_imm_a_d, bus_imm_b_q, bus_imm_b_d;

  // A lone requester always wins; the pointer only breaks ties.
  always_comb begin
    gnt_a = ~Reset & ReqA & (~ReqB | (ptr_q == PTR_A));
    gnt_b = ~Reset & ReqB & (~ReqA | (ptr_q == PTR_B));
    ptr_d = ptr_q;
    if (ReqA && ReqB) begin
      ptr_d = gnt_a ? PTR_B : PTR_A;
    end
  end

  always_comb begin
    sel_imm  = gnt_b ? ImmB  : ImmA;
    sel_ctrl = gnt_b ? CtrlB : CtrlA;
  end

  imm_extend u_extend (
    .imm  (sel_imm),
    .ctrl (sel_ctrl),
    .ext  (ext_imm)
  );

  always_comb begin
    rsp_valid_a_d = gnt_a;
    rsp_valid_b_d = gnt_b;
    bus_imm_a_d   = gnt_a ? ext_imm : bus_imm_a_q;
    bus_imm_b_d   = gnt_b ? ext_imm : bus_imm_b_q;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      ptr_q         <= PTR_A;
      rsp_valid_a_q <= 1'b0;
      rsp_valid_b_q <= 1'b0;
      bus_imm_a_q   <= '0;
      bus_imm_b_q   <= '0;
    end else begin
      ptr_q         <= ptr_d;
      rsp_valid_a_q <= rsp_valid_a_d;
      rsp_valid_b_q <= rsp_valid_b_d;
      bus_imm_a_q   <= bus_imm_a_d;
      bus_imm_b_q   <= bus_imm_b_d;
    end
  end

  // Outputs read as idle for the whole reset assertion, including its first cycle.
  always_comb begin
    GntA      = gnt_a;
    GntB      = gnt_b;
    RspValidA = rsp_valid_a_q & ~Reset;
    RspValidB = rsp_valid_b_q & ~Reset;
    BusImmA   = Reset ? 64'h0 : bus_imm_a_q;
    BusImmB   = Reset ? 64'h0 : bus_imm_b_q;
  end

`ifdef IMM_EXT_STALL_CNT_EN
  logic [15:0] stall_cnt_a_q, stall_cnt_a_d, stall_cnt_b_q, stall_cnt_b_d;

  always_comb begin
    stall_cnt_a_d = stall_cnt_a_q;
    stall_cnt_b_d = stall_cnt_b_q;
    if (ReqA && !gnt_a && stall_cnt_a_q != 16'hFFFF) stall_cnt_a_d = stall_cnt_a_q + 16'd1;
    if (ReqB && !gnt_b && stall_cnt_b_q != 16'hFFFF) stall_cnt_b_d = stall_cnt_b_q + 16'd1;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      stall_cnt_a_q <= '0;
      stall_cnt_b_q <= '0;
    end else begin
      stall_cnt_a_q <= stall_cnt_a_d;
      stall_cnt_b_q <= stall_cnt_b_d;
    end
  end

  assign StallCntA = stall_cnt_a_q;
  assign StallCntB = stall_cnt_b_q;
`endif

endmodule
